// File: rtl/i2c_slave_regif.sv
// I2C target exposing a byte-wide register space through one-cycle strobes.
// A pointer byte follows the device address; writes and reads auto-increment it.
module i2c_slave_regif #(
  parameter logic [6:0]  SLAVE_ADDR = 7'h50,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  scl_pad_i,
  input  logic                  sda_pad_i,
  output logic                  sda_pad_o,
  output logic                  sda_padoen_o,
  output logic [ADDR_WIDTH-1:0] reg_addr_o,
  output logic [7:0]            reg_wdata_o,
  output logic                  reg_we_o,
  output logic                  reg_re_o,
  input  logic [7:0]            reg_rdata_i,
  output logic                  busy_o
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP
  } state_e;

  state_e                 state_q, state_d;
  logic [2:0]             sclSync_q, sdaSync_q;
  logic [3:0]             bitCnt_q, bitCnt_d;
  logic [7:0]             rxShift_q, rxShift_d;
  logic [7:0]             txShift_q, txShift_d;
  logic                   rw_q, rw_d;
  logic                   ack_q, ack_d;
  logic                   sdaOen_q, sdaOen_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [7:0]             wdata_q, wdata_d;
  logic                   busy_q, busy_d;
  logic                   msbPending_q, msbPending_d;
  logic                   rdLatch_q;
  logic                   reStrobe, weStrobe;
  logic                   sclRise, sclFall, sdaIn, startCond, stopCond;
  logic [7:0]             rxByte;

  // Bit [1] is the synchronized level, bit [2] the previous sample for edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclSync_q <= 3'b111;
      sdaSync_q <= 3'b111;
    end else begin
      sclSync_q <= {sclSync_q[1:0], scl_pad_i};
      sdaSync_q <= {sdaSync_q[1:0], sda_pad_i};
    end
  end

  assign sclRise   = sclSync_q[1] & ~sclSync_q[2];
  assign sclFall   = ~sclSync_q[1] & sclSync_q[2];
  assign sdaIn     = sdaSync_q[1];
  assign startCond = sclSync_q[1] & sclSync_q[2] & sdaSync_q[2] & ~sdaSync_q[1];
  assign stopCond  = sclSync_q[1] & sclSync_q[2] & ~sdaSync_q[2] & sdaSync_q[1];
  assign rxByte    = {rxShift_q[6:0], sdaIn};

  always_comb begin
    state_d      = state_q;
    bitCnt_d     = bitCnt_q;
    rxShift_d    = rxShift_q;
    txShift_d    = txShift_q;
    rw_d         = rw_q;
    ack_d        = ack_q;
    sdaOen_d     = sdaOen_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    busy_d       = busy_q;
    msbPending_d = msbPending_q;
    reStrobe     = 1'b0;
    weStrobe     = 1'b0;

    // Read data arrives one clock after the strobe; after a master ACK the MSB waits for it.
    if (rdLatch_q) begin
      txShift_d = reg_rdata_i;
      if (msbPending_q) begin
        sdaOen_d     = reg_rdata_i[7];
        msbPending_d = 1'b0;
      end
    end

    if (startCond) begin
      state_d      = ADDR;
      bitCnt_d     = '0;
      sdaOen_d     = 1'b1;
      msbPending_d = 1'b0;
    end else if (stopCond) begin
      state_d      = IDLE;
      bitCnt_d     = '0;
      sdaOen_d     = 1'b1;
      busy_d       = 1'b0;
      msbPending_d = 1'b0;
    end else begin
      if (sclRise && bitCnt_q != 4'd8 && (state_q inside {ADDR, PTR, WDATA, RDATA})) begin
        rxShift_d = rxByte;
        bitCnt_d  = bitCnt_q + 4'd1;
      end
      case (state_q)
        ADDR: begin
          if (sclFall && bitCnt_q == 4'd8) begin
            bitCnt_d = '0;
            if (rxShift_q[7:1] == SLAVE_ADDR) begin
              state_d  = ADDR_ACK;
              sdaOen_d = 1'b0;
              busy_d   = 1'b1;
              rw_d     = rxShift_q[0];
              reStrobe = rxShift_q[0];
            end else begin
              state_d = WAIT_STOP;
              busy_d  = 1'b0;
            end
          end
        end
        ADDR_ACK: begin
          if (sclFall) begin
            state_d  = rw_q ? RDATA : PTR;
            sdaOen_d = rw_q ? txShift_q[7] : 1'b1;
          end
        end
        PTR: begin
          if (sclFall && bitCnt_q == 4'd8) begin
            addr_d   = ADDR_WIDTH'(rxShift_q);
            sdaOen_d = 1'b0;
            bitCnt_d = '0;
            state_d  = PTR_ACK;
          end
        end
        PTR_ACK: begin
          if (sclFall) begin
            sdaOen_d = 1'b1;
            state_d  = WDATA;
          end
        end
        WDATA: begin
          if (sclRise && bitCnt_q == 4'd7) wdata_d = rxByte;
          if (sclFall && bitCnt_q == 4'd8) begin
            weStrobe = 1'b1;
            sdaOen_d = 1'b0;
            bitCnt_d = '0;
            state_d  = WDATA_ACK;
          end
        end
        WDATA_ACK: begin
          if (sclFall) begin
            sdaOen_d = 1'b1;
            addr_d   = addr_q + ADDR_WIDTH'(1);
            state_d  = WDATA;
          end
        end
        RDATA: begin
          // ~bitCnt selects bit 7-n: bit 7 went out on entry, bits 6..0 follow each fall.
          if (sclFall && bitCnt_q == 4'd8) begin
            sdaOen_d = 1'b1;
            bitCnt_d = '0;
            state_d  = RDATA_ACK;
          end else if (sclFall && bitCnt_q != 4'd0) begin
            sdaOen_d = txShift_q[~bitCnt_q[2:0]];
          end
        end
        RDATA_ACK: begin
          if (sclRise) begin
            ack_d = sdaIn;
            if (!sdaIn) addr_d = addr_q + ADDR_WIDTH'(1);
          end else if (sclFall) begin
            if (!ack_q) begin
              state_d      = RDATA;
              reStrobe     = 1'b1;
              msbPending_d = 1'b1;
            end else begin
              state_d = WAIT_STOP;
            end
          end
        end
        IDLE, WAIT_STOP: ;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      bitCnt_q     <= '0;
      rxShift_q    <= '0;
      txShift_q    <= '0;
      rw_q         <= 1'b0;
      ack_q        <= 1'b1;
      sdaOen_q     <= 1'b1;
      addr_q       <= '0;
      wdata_q      <= '0;
      busy_q       <= 1'b0;
      msbPending_q <= 1'b0;
      rdLatch_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      bitCnt_q     <= bitCnt_d;
      rxShift_q    <= rxShift_d;
      txShift_q    <= txShift_d;
      rw_q         <= rw_d;
      ack_q        <= ack_d;
      sdaOen_q     <= sdaOen_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      busy_q       <= busy_d;
      msbPending_q <= msbPending_d;
      rdLatch_q    <= reStrobe;
    end
  end

  assign sda_pad_o    = 1'b0;
  assign sda_padoen_o = sdaOen_q;
  assign reg_addr_o   = addr_q;
  assign reg_wdata_o  = wdata_q;
  assign reg_we_o     = weStrobe;
  assign reg_re_o     = reStrobe;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_i2c_slave_regif.sv
// Bench for i2c_slave_regif: an I2C master model drives byte transactions and
// a register-file model predicts strobes, read data and ACKs.
module tb_i2c_slave_regif;

  localparam int         Q        = 8;
  localparam logic [6:0] DEV_ADDR = 7'h50;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       masterScl, masterSda;
  logic       sdaBus;
  logic       sda_pad_o, sda_padoen_o;
  logic [7:0] reg_addr_o, reg_wdata_o, rdataReg;
  logic       reg_we_o, reg_re_o, busy_o;

  int checks   = 0;
  int failures = 0;

  logic [7:0] wrAddrQ[$];
  logic [7:0] wrDataQ[$];
  logic [7:0] rdAddrQ[$];
  logic [7:0] periphMem [256];
  logic       periphValid [256];
  logic [7:0] modelMem [256];
  logic [7:0] wb [4];
  int         strobeErr  = 0;
  int         oenLowCnt  = 0;
  int         busyCnt    = 0;
  logic       weLast     = 1'b0;
  logic       reLast     = 1'b0;

  always #5 clk = ~clk;

  // Open-drain bus: either side may pull low.
  assign sdaBus = masterSda & (sda_padoen_o | sda_pad_o);

  i2c_slave_regif #(.SLAVE_ADDR(DEV_ADDR), .ADDR_WIDTH(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .scl_pad_i    (masterScl),
    .sda_pad_i    (sdaBus),
    .sda_pad_o    (sda_pad_o),
    .sda_padoen_o (sda_padoen_o),
    .reg_addr_o   (reg_addr_o),
    .reg_wdata_o  (reg_wdata_o),
    .reg_we_o     (reg_we_o),
    .reg_re_o     (reg_re_o),
    .reg_rdata_i  (rdataReg),
    .busy_o       (busy_o)
  );

  function automatic logic [7:0] initVal(input logic [7:0] a);
    return a * 8'd37 + 8'd91;
  endfunction

  // Register-file stand-in: logs strobes and returns data one clock after reg_re_o.
  always @(negedge clk) begin
    if (reg_re_o) begin
      rdataReg = periphValid[reg_addr_o] ? periphMem[reg_addr_o] : initVal(reg_addr_o);
      rdAddrQ.push_back(reg_addr_o);
    end
    if (reg_we_o) begin
      periphMem[reg_addr_o]   = reg_wdata_o;
      periphValid[reg_addr_o] = 1'b1;
      wrAddrQ.push_back(reg_addr_o);
      wrDataQ.push_back(reg_wdata_o);
    end
    if (reg_we_o && reg_re_o) strobeErr++;
    if ((reg_we_o && weLast) || (reg_re_o && reLast)) strobeErr++;
    weLast = reg_we_o;
    reLast = reg_re_o;
    if (!sda_padoen_o) oenLowCnt++;
    if (busy_o) busyCnt++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic waitQ();
    repeat (Q) @(posedge clk);
    #2;
  endtask

  task automatic i2cStart();
    masterSda = 1'b1; waitQ();
    masterScl = 1'b1; waitQ();
    masterSda = 1'b0; waitQ();
    masterScl = 1'b0; waitQ();
  endtask

  task automatic i2cStop();
    masterSda = 1'b0; waitQ();
    masterScl = 1'b1; waitQ();
    masterSda = 1'b1; waitQ();
  endtask

  task automatic clockBit(input logic b, output logic sampled);
    masterSda = b;    waitQ();
    masterScl = 1'b1; waitQ();
    sampled   = sdaBus; waitQ();
    masterScl = 1'b0; waitQ();
  endtask

  task automatic writeByte(input logic [7:0] data, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clockBit(data[i], s);
    clockBit(1'b1, ack);
  endtask

  task automatic readByte(input logic ackVal, output logic [7:0] data);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clockBit(1'b1, s);
      data[i] = s;
    end
    clockBit(ackVal, s);
  endtask

  // One full transaction: pointer write, then either n data writes or n reads.
  task automatic applyStimulus(input bit isRead, input logic [7:0] ptr, input int n,
                               input logic [7:0] wbytes [4]);
    logic       ack;
    logic [7:0] got;
    int         wrBase, rdBase, idx;
    wrBase = wrAddrQ.size();
    rdBase = rdAddrQ.size();
    i2cStart();
    writeByte({DEV_ADDR, 1'b0}, ack);
    checkOutput("addrAckW", ack, 0);
    checkOutput("busyAfterMatch", busy_o, 1);
    writeByte(ptr, ack);
    checkOutput("ptrAck", ack, 0);
    if (isRead) begin
      i2cStart();
      writeByte({DEV_ADDR, 1'b1}, ack);
      checkOutput("addrAckR", ack, 0);
      for (int i = 0; i < n; i++) begin
        readByte(i == n - 1, got);
        checkOutput("rdData", got, modelMem[8'(ptr + i)]);
      end
    end else begin
      for (int i = 0; i < n; i++) begin
        writeByte(wbytes[i], ack);
        checkOutput("wrAck", ack, 0);
        modelMem[8'(ptr + i)] = wbytes[i];
      end
    end
    i2cStop();
    waitQ();
    checkOutput("busyAfterStop", busy_o, 0);
    checkOutput("oenAfterStop", sda_padoen_o, 1);
    if (isRead) begin
      checkOutput("rdCount", rdAddrQ.size() - rdBase, n);
      checkOutput("wrCountInRead", wrAddrQ.size() - wrBase, 0);
      for (int i = 0; i < n; i++) begin
        idx = rdBase + i;
        checkOutput("rdAddr", (idx < rdAddrQ.size()) ? 32'(rdAddrQ[idx]) : 32'hFFFF_FFFF,
                    32'(8'(ptr + i)));
      end
    end else begin
      checkOutput("wrCount", wrAddrQ.size() - wrBase, n);
      checkOutput("rdCountInWrite", rdAddrQ.size() - rdBase, 0);
      for (int i = 0; i < n; i++) begin
        idx = wrBase + i;
        checkOutput("wrAddr", (idx < wrAddrQ.size()) ? 32'(wrAddrQ[idx]) : 32'hFFFF_FFFF,
                    32'(8'(ptr + i)));
        checkOutput("wrData", (idx < wrDataQ.size()) ? 32'(wrDataQ[idx]) : 32'hFFFF_FFFF,
                    32'(wbytes[i]));
      end
    end
    waitQ();
  endtask

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic ack, s;
    int   oenBase, busyBase, wrBase, rdBase;

    for (int a = 0; a < 256; a++) modelMem[a] = initVal(8'(a));
    rst_n     = 1'b0;
    masterScl = 1'b1;
    masterSda = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    checkOutput("rstOen", sda_padoen_o, 1);
    checkOutput("rstPadO", sda_pad_o, 0);
    checkOutput("rstAddr", reg_addr_o, 0);
    checkOutput("rstWdata", reg_wdata_o, 0);
    checkOutput("rstWe", reg_we_o, 0);
    checkOutput("rstRe", reg_re_o, 0);
    checkOutput("rstBusy", busy_o, 0);
    rst_n = 1'b1;
    waitQ();

    $display("[TB] directed write 0x10 <= 5A C3");
    wb = '{8'h5A, 8'hC3, 8'h00, 8'h00};
    applyStimulus(1'b0, 8'h10, 2, wb);

    $display("[TB] directed read 0x20 (96, 3C)");
    wb = '{8'h96, 8'h3C, 8'h00, 8'h00};
    applyStimulus(1'b0, 8'h20, 2, wb);
    applyStimulus(1'b1, 8'h20, 2, wb);

    $display("[TB] address mismatch");
    oenBase  = oenLowCnt;
    busyBase = busyCnt;
    wrBase   = wrAddrQ.size();
    rdBase   = rdAddrQ.size();
    i2cStart();
    writeByte(8'hB0, ack);
    checkOutput("mmAddrNack", ack, 1);
    writeByte(8'h12, ack);
    checkOutput("mmDataNack", ack, 1);
    i2cStop();
    waitQ();
    checkOutput("mmOenNeverLow", oenLowCnt - oenBase, 0);
    checkOutput("mmBusyNeverHigh", busyCnt - busyBase, 0);
    checkOutput("mmNoStrobes", (wrAddrQ.size() - wrBase) + (rdAddrQ.size() - rdBase), 0);

    $display("[TB] pointer wrap");
    wb = '{8'h01, 8'h02, 8'h00, 8'h00};
    applyStimulus(1'b0, 8'hFF, 2, wb);
    applyStimulus(1'b1, 8'hFF, 2, wb);

    $display("[TB] abort mid data byte");
    wrBase = wrAddrQ.size();
    i2cStart();
    writeByte({DEV_ADDR, 1'b0}, ack);
    writeByte(8'h40, ack);
    for (int i = 0; i < 4; i++) clockBit(1'($urandom), s);
    i2cStop();
    waitQ();
    checkOutput("abortNoWrite", wrAddrQ.size() - wrBase, 0);
    checkOutput("abortBusy", busy_o, 0);
    checkOutput("abortOen", sda_padoen_o, 1);
    wb = '{8'hE7, 8'h18, 8'h00, 8'h00};
    applyStimulus(1'b0, 8'h40, 2, wb);

    $display("[TB] random transactions");
    for (int t = 0; t < 14; t++) begin
      for (int k = 0; k < 4; k++) wb[k] = 8'($urandom);
      applyStimulus(1'($urandom_range(0, 1)), 8'($urandom), int'($urandom_range(1, 4)), wb);
    end

    $display("[TB] async reset during address ACK");
    i2cStart();
    for (int i = 7; i >= 0; i--) clockBit(((8'hA0 >> i) & 8'h01) != 0, s);
    masterSda = 1'b1;
    checkOutput("preResetOen", sda_padoen_o, 0);
    checkOutput("preResetBusy", busy_o, 1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("asyncRstOen", sda_padoen_o, 1);
    checkOutput("asyncRstBusy", busy_o, 0);
    checkOutput("asyncRstAddr", reg_addr_o, 0);
    checkOutput("asyncRstWdata", reg_wdata_o, 0);
    checkOutput("asyncRstStrobes", {reg_we_o, reg_re_o}, 0);
    masterScl = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b1;
    waitQ();
    wb = '{8'h33, 8'h00, 8'h00, 8'h00};
    applyStimulus(1'b0, 8'h77, 1, wb);
    applyStimulus(1'b1, 8'h77, 1, wb);

    checkOutput("strobeRules", strobeErr, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2c_slave_regif.md
Name: i2c_slave_regif

Overview:
- I2C target (slave) that responds to the SoC I2C master from the other side of the same two-wire bus; used on bench boards and in companion dies to expose a byte-wide register space.
- Decodes START/STOP, matches a 7-bit device address, and takes a register pointer byte.
- Then performs auto-incrementing register writes/reads through a simple one-cycle strobe interface.
- Pad-side signalling uses the same pad_i / pad_o / padoen_o split as the SoC pads, with open-drain use of SDA.

Parameters:
- SLAVE_ADDR, 7'h50, 7-bit device address matched after START.
- ADDR_WIDTH, 8, register pointer width; pointer wraps modulo 2^ADDR_WIDTH.

Ports:
- clk  input  1  system clock, at least 8x SCL frequency.
- rst_n  input  1  asynchronous active-low reset.
- scl_pad_i  input  1  SCL from pad, asynchronous.
- sda_pad_i  input  1  SDA from pad, asynchronous.
- sda_pad_o  output  1  SDA output value, constant 0 (open drain).
- sda_padoen_o  output  1  SDA output enable, active-low: 0 pulls SDA low, 1 releases.
- reg_addr_o  output  ADDR_WIDTH  current register pointer.
- reg_wdata_o  output  8  received data byte.
- reg_we_o  output  1  one-cycle write strobe.
- reg_re_o  output  1  one-cycle read strobe.
- reg_rdata_i  input  8  read data, sampled exactly 1 clk after reg_re_o.
- busy_o  output  1  high from address match to STOP/abort.

Behaviour:
- Reset: sda_padoen_o=1, sda_pad_o=0, reg_addr_o=0, reg_wdata_o=0, reg_we_o=0, reg_re_o=0, busy_o=0, state IDLE.
- Input conditioning:
  - scl_pad_i and sda_pad_i each pass through a 2-flop synchronizer (reset value 1), plus a 3rd flop for edge detect.
  - SCL rise = sampled 0->1; SCL fall = sampled 1->0.
  - START: SDA 1->0 while SCL=1. STOP: SDA 0->1 while SCL=1. These take priority over bit processing in the same cycle.
- Bit rules:
  - SDA is sampled on SCL rise.
  - The target changes SDA only on SCL fall.
  - Bytes are MSB first; a bit counter 0..8 counts bit 8 as the ACK slot.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP.
- START from any state -> ADDR (repeated START is legal); bit counter cleared; SDA released.
- STOP from any state -> IDLE; SDA released; busy_o=0.
- ADDR:
  - After 8 bits, compare bits[7:1] to SLAVE_ADDR.
  - Mismatch -> WAIT_STOP, never driving SDA (WAIT_STOP ignores everything except START/STOP).
  - Match -> ADDR_ACK: pull SDA low on the following SCL fall; busy_o=1.
  - With R/W=1, reg_re_o pulses in the same cycle as that SCL fall.
- ADDR_ACK: release SDA on the next SCL fall. Then R/W=0 -> PTR; R/W=1 -> RDATA.
  - For RDATA the first data bit is driven at that same fall, using the byte latched from reg_rdata_i.
- PTR: 8 bits load reg_addr_o (low ADDR_WIDTH bits); ACK -> PTR_ACK -> WDATA.
- WDATA:
  - After 8 bits, reg_wdata_o is updated and reg_we_o pulses once on the SCL fall that begins the ACK.
  - The target ACKs; after the ACK fall, reg_addr_o increments (wrap) and the state returns to WDATA.
- RDATA:
  - Shift register drives sda_padoen_o = current bit (1 releases, 0 pulls).
  - After 8 bits, SDA is released and the master's ACK is sampled on SCL rise in RDATA_ACK.
  - ACK(0): reg_addr_o increments; on the next SCL fall reg_re_o pulses and the next byte is latched 1 clk later, before its MSB is driven.
  - NACK(1): -> WAIT_STOP with SDA released.
- Latency: SDA changes 3 clk after the SCL fall at the pad (sync + edge-detect); the clock-ratio requirement guarantees data setup.
- reg_we_o and reg_re_o are never high in the same cycle and never high for more than 1 clk.
- Reset mid-transfer: immediate return to reset values; SDA released asynchronously.

Test Plan:
- Write: START, 0xA0, ptr 0x10, data 0x5A, 0xC3, STOP -> ACK on all 4 bytes; reg_we_o pulses twice with (addr 0x10, 0x5A) then (0x11, 0xC3); busy_o drops after STOP.
- Read: START, 0xA0, ptr 0x20, rSTART, 0xA1, reg_rdata_i = 0x96 then 0x3C, master ACK then NACK, STOP -> SDA carries 0x96, 0x3C; reg_re_o pulses at addr 0x20 and 0x21; no third pulse.
- Address mismatch: START, 0xB0, 0x12, STOP -> sda_padoen_o stays 1 throughout; no strobes; busy_o stays 0.
- Pointer wrap: write ptr 0xFF, data 0x01, 0x02 -> writes at 0xFF then 0x00.
- Abort: STOP after 4 bits of WDATA -> IDLE, no reg_we_o, SDA released; a following write transaction succeeds.
- Async reset asserted while the target is pulling SDA low in an ACK -> sda_padoen_o=1 with no clk edge required; all outputs at reset values.
